// File: rtl/cci_mpf_prim_sort_rsp_nport.sv
// Reorder scoreboard: N-port out-of-order completions, in-order release.
// Define CCI_MPF_SORT_RSP_ERR_CHK_EN to build the protocol error checks.
module cci_mpf_prim_sort_rsp_nport #(
  parameter int N_ENTRIES = 256,
  parameter int N_MDATA_BITS = 16,
  parameter int N_RSP_PORTS = 2,
  parameter int MIN_FREE_SLOTS = 8,
  localparam int IDX_BITS = $clog2(N_ENTRIES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            alloc_en,
  input  logic [N_MDATA_BITS-1:0]         alloc_mdata,
  output logic [IDX_BITS-1:0]             alloc_idx,
  output logic                            alm_full,
  input  logic [N_RSP_PORTS-1:0]          cpl_en,
  input  logic [N_RSP_PORTS*IDX_BITS-1:0] cpl_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_MDATA_BITS-1:0]         out_mdata,
  output logic                            err
);

  localparam int CNT_W = IDX_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ENTRIES);
  localparam logic [CNT_W-1:0] ALM_TH =
    CNT_W'(N_ENTRIES - MIN_FREE_SLOTS);

  logic [IDX_BITS-1:0]     head_q, head_d;
  logic [IDX_BITS-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [N_ENTRIES-1:0]    done_q, done_d;
  logic                    alm_full_q, alm_full_d;
  logic [N_MDATA_BITS-1:0] mdata_q [N_ENTRIES];
  logic                    deq;
  logic                    alloc_ok;

  assign out_valid = (count_q != '0) && done_q[head_q];
  assign out_mdata = mdata_q[head_q];
  assign deq       = out_valid && out_ready;
  // A full scoreboard still accepts an alloc when the head leaves this cycle
  assign alloc_ok  = alloc_en && ((count_q != CNT_FULL) || deq);
  assign alloc_idx = tail_q;
  assign alm_full  = alm_full_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (alloc_ok) begin
      done_d[tail_q] = 1'b0;
      tail_d = tail_q + 1'b1;
    end
    if (deq) begin
      done_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
    end
    case ({alloc_ok, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    for (int p = 0; p < N_RSP_PORTS; p++) begin
      if (cpl_en[p]) done_d[cpl_idx[p*IDX_BITS +: IDX_BITS]] = 1'b1;
    end
    alm_full_d = (count_d >= ALM_TH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      done_q     <= '0;
      alm_full_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      done_q     <= done_d;
      alm_full_q <= alm_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) mdata_q[tail_q] <= alloc_mdata;
  end

`ifdef CCI_MPF_SORT_RSP_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    logic [IDX_BITS-1:0] ip, iq, off;
    err_d = err_q;
    ip    = '0;
    iq    = '0;
    off   = '0;
    if (alloc_en && (count_q == CNT_FULL) && !deq) err_d = 1'b1;
    for (int p = 0; p < N_RSP_PORTS; p++) begin
      ip  = cpl_idx[p*IDX_BITS +: IDX_BITS];
      off = ip - head_q;
      if (cpl_en[p]) begin
        // Outside the live window [head, tail)
        if ({1'b0, off} >= count_q) err_d = 1'b1;
        if (done_q[ip]) err_d = 1'b1;
        for (int q = p + 1; q < N_RSP_PORTS; q++) begin
          iq = cpl_idx[q*IDX_BITS +: IDX_BITS];
          if (cpl_en[q] && (iq == ip)) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cci_mpf_prim_sort_rsp_nport.sv
// Bench for the reorder scoreboard: directed scenarios plus random traffic
// checked against a queue-of-entries reference model.
module tb_cci_mpf_prim_sort_rsp_nport;

  localparam int N   = 8;
  localparam int MIN = 2;
  localparam int MW  = 16;
  localparam int NP  = 2;
  localparam int IB  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alloc_en;
  logic [MW-1:0] alloc_mdata;
  logic [IB-1:0] alloc_idx;
  logic          alm_full;
  logic [NP-1:0] cpl_en;
  logic [NP*IB-1:0] cpl_idx;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mdata;
  logic          err;

  cci_mpf_prim_sort_rsp_nport #(
    .N_ENTRIES(N),
    .N_MDATA_BITS(MW),
    .N_RSP_PORTS(NP),
    .MIN_FREE_SLOTS(MIN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .alloc_en(alloc_en),
    .alloc_mdata(alloc_mdata),
    .alloc_idx(alloc_idx),
    .alm_full(alm_full),
    .cpl_en(cpl_en),
    .cpl_idx(cpl_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mdata(out_mdata),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] md;
    bit          done;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  bit   exp_alm;
  bit   exp_err;
  int   nvec;
  int   nerr;

  function automatic bit exp_valid();
    return (q.size() > 0) && q[0].done;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    exp_alm = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic step(input bit a, input int md, input bit [1:0] ce,
                      input int i0, input int i1, input bit rdy);
    bit deq, aok;
    int ci[2];
    alloc_en    = a;
    alloc_mdata = MW'(md);
    cpl_en      = ce;
    cpl_idx     = {IB'(i1), IB'(i0)};
    out_ready   = rdy;
    #1;
    chk("out_valid", int'(out_valid), int'(exp_valid()));
    if (exp_valid()) chk("out_mdata", int'(out_mdata), int'(q[0].md));
    chk("alloc_idx", int'(alloc_idx), m_tail);
    chk("alm_full", int'(alm_full), int'(exp_alm));
    chk("err", int'(err), int'(exp_err));
    deq = exp_valid() && rdy;
    aok = a && ((q.size() < N) || deq);
    if (deq) void'(q.pop_front());
    if (aok) begin
      q.push_back('{idx: m_tail, md: 16'(md), done: 1'b0});
      m_tail = (m_tail + 1) % N;
    end
    ci[0] = i0 % N;
    ci[1] = i1 % N;
    for (int p = 0; p < 2; p++) begin
      if (ce[p]) begin
        foreach (q[k]) if (q[k].idx == ci[p]) q[k].done = 1'b1;
      end
    end
    exp_alm = ((N - q.size()) <= MIN);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 2'b00, 0, 0, rdy);
  endtask

  // Complete oldest pending entry each cycle and accept everything
  task automatic drain();
    int pend;
    for (int c = 0; c < 64 && q.size() > 0; c++) begin
      pend = -1;
      foreach (q[k]) if (pend < 0 && !q[k].done) pend = q[k].idx;
      if (pend >= 0) step(1'b0, 0, 2'b01, pend, 0, 1'b1);
      else           idle(1'b1);
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int p0, p1, np;
    bit [1:0] ce;
    alloc_en    = 1'b0;
    alloc_mdata = '0;
    cpl_en      = '0;
    cpl_idx     = '0;
    out_ready   = 1'b0;
    nvec = 0;
    nerr = 0;
    model_reset();

    reset_n = 1'b0;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_almf", int'(alm_full), 0);
    chk("rst_idx", int'(alloc_idx), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // In-order release of reversed completions
    step(1'b1, 'hA, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'hB, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'hC, 2'b00, 0, 0, 1'b0);
    step(1'b0, 0, 2'b01, 2, 0, 1'b1);
    step(1'b0, 0, 2'b01, 1, 0, 1'b1);
    step(1'b0, 0, 2'b01, 0, 0, 1'b1);
    chk("first_valid", int'(out_valid), 1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("empty_after3", int'(out_valid), 0);

    // Two ports completing in the same cycle
    step(1'b1, 'hA, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'hB, 2'b00, 0, 0, 1'b0);
    step(1'b0, 0, 2'b11, q[1].idx, q[0].idx, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Almost-full threshold and full-with-deq behaviour, wrapping tail
    for (int i = 0; i < 6; i++) step(1'b1, 'h100 + i, 2'b00, 0, 0, 1'b0);
    chk("almf_6", int'(alm_full), 1);
    step(1'b1, 'h106, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'h107, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'h1FF, 2'b01, q[0].idx, 0, 1'b0);
    chk("full_ignore_idx", int'(alloc_idx), m_tail);
    idle(1'b0);
    step(1'b1, 'h200, 2'b00, 0, 0, 1'b1);
    chk("full_swap_almf", int'(alm_full), 1);
    drain();
    chk("almf_drained", int'(alm_full), 0);

    // Async reset with 3 outstanding, head already completed
    step(1'b1, 'h31, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'h32, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'h33, 2'b01, q[0].idx, 0, 1'b0);
    idle(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_idx", int'(alloc_idx), 0);
    chk("arst_almf", int'(alm_full), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random legal traffic
    for (int c = 0; c < 400; c++) begin
      p0 = -1;
      p1 = -1;
      np = 0;
      foreach (q[k]) if (!q[k].done) np++;
      ce = 2'b00;
      if (np > 0 && $urandom_range(0, 99) < 60) begin
        p0 = $urandom_range(0, np - 1);
        ce[0] = 1'b1;
      end
      if (np > 1 && $urandom_range(0, 99) < 40) begin
        p1 = $urandom_range(0, np - 1);
        if (p1 != p0) ce[1] = 1'b1;
      end
      begin
        int j, i0, i1;
        j = 0;
        i0 = 0;
        i1 = 0;
        foreach (q[k]) begin
          if (!q[k].done) begin
            if (j == p0) i0 = q[k].idx;
            if (j == p1) i1 = q[k].idx;
            j++;
          end
        end
        step($urandom_range(0, 99) < 55, int'($urandom_range(0, 65535)),
             ce, i0, i1, $urandom_range(0, 99) < 70);
      end
    end
    drain();

`ifdef CCI_MPF_SORT_RSP_ERR_CHK_EN
    step(1'b1, 'h51, 2'b00, 0, 0, 1'b0);
    step(1'b1, 'h52, 2'b00, 0, 0, 1'b0);
    step(1'b0, 0, 2'b01, q[1].idx, 0, 1'b0);
    step(1'b0, 0, 2'b01, q[1].idx, 0, 1'b0);
    exp_err = 1'b1;
    idle(1'b0);
    idle(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("err_clr", int'(err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
`endif
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
